// File: rtl/multi_pulse_width_detector_pkg.sv
// multi_pulse_det_pkg: shared polarity encoding and width-counter sizing for the pulse width detector
// No ports. width_cw(max_w) gives the counter width able to hold the saturated value MAX_W+1.
package multi_pulse_det_pkg;

    typedef enum logic {POL_LOW = 1'b0, POL_HIGH = 1'b1} pol_e;

    function automatic int width_cw(input int max_w);
        return $clog2(max_w + 2);
    endfunction

endpackage

// File: rtl/multi_pulse_width_detector_if.sv
// multi_pulse_width_detector_if: channel inputs and per-channel event/width outputs of the detector
// Signals: a (raw inputs), rise, fall, detected, too_long (strobes), width (packed, channel k at [k*CW +: CW]).
// Modports: master drives a and observes results; slave is the detector side.
interface multi_pulse_width_detector_if
    import multi_pulse_det_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int MAX_W = 1
);
    localparam int CW = width_cw(MAX_W);

    logic [N_CH-1:0]    a;
    logic [N_CH-1:0]    rise;
    logic [N_CH-1:0]    fall;
    logic [N_CH-1:0]    detected;
    logic [N_CH-1:0]    too_long;
    logic [N_CH*CW-1:0] width;

    modport master (output a, input rise, fall, detected, too_long, width);
    modport slave  (input a, output rise, fall, detected, too_long, width);

endinterface

// File: rtl/multi_pulse_width_detector_channel.sv
// pulse_width_channel: one channel of edge detection and pulse width measurement
// Ports: clk, rst (sync, active-low), a (raw input); rise/fall/detected/too_long strobes; width of the pulse ending this cycle.
// Option: MULTI_PULSE_DET_SYNC_EN inserts a 2-flop synchronizer on a (outputs then lag the input by 2 cycles).
module pulse_width_channel
    import multi_pulse_det_pkg::*;
#(
    parameter int MIN_W    = 1,
    parameter int MAX_W    = 1,
    parameter int POLARITY = 1,
    parameter int CW       = width_cw(MAX_W)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a,
    output logic          rise,
    output logic          fall,
    output logic          detected,
    output logic          too_long,
    output logic [CW-1:0] width
);
    localparam logic          ACT  = (POLARITY == int'(POL_HIGH));
    localparam logic [CW-1:0] SAT  = CW'(MAX_W + 1);
    localparam logic [CW-1:0] MAXV = CW'(MAX_W);
    localparam logic [CW-1:0] MINV = CW'(MIN_W);

    logic          a_s, a_r, act, act_r;
    logic [CW-1:0] cnt;

`ifdef MULTI_PULSE_DET_SYNC_EN
    logic [1:0] sync;
    always_ff @(posedge clk)
        sync <= !rst ? {2{~ACT}} : {sync[0], a};
    assign a_s = sync[1];
`else
    assign a_s = a;
`endif

    assign act   = (a_s == ACT);
    assign act_r = (a_r == ACT);

    // Counter saturates at MAX_W+1 so an overlong pulse never wraps back into range.
    always_ff @(posedge clk) begin
        a_r <= !rst ? ~ACT : a_s;
        cnt <= (!rst || !act) ? '0 : !act_r ? CW'(1) : (cnt == SAT) ? SAT : cnt + 1'b1;
    end

    // Outputs are forced low during reset so a mid-pulse reset reports nothing.
    assign rise     = rst & act & ~act_r;
    assign fall     = rst & ~act & act_r;
    assign detected = fall & (cnt >= MINV) & (cnt <= MAXV);
    assign too_long = rst & act & act_r & (cnt == MAXV);
    assign width    = fall ? cnt : '0;

endmodule

// File: rtl/multi_pulse_width_detector.sv
// multi_pulse_width_detector: N_CH independent pulse edge/width detectors with in-range detect strobes
// Ports: clk, rst (sync, active-low), bus (slave modport: a in; rise, fall, detected, too_long, width out).
// Option: MULTI_PULSE_DET_SYNC_EN adds a 2-flop synchronizer per input (2-cycle output latency).
module multi_pulse_width_detector
    import multi_pulse_det_pkg::*;
#(
    parameter int N_CH     = 4,
    parameter int MIN_W    = 1,
    parameter int MAX_W    = 1,
    parameter int POLARITY = 1
) (
    input logic                         clk,
    input logic                         rst,
    multi_pulse_width_detector_if.slave bus
);
    localparam int CW = width_cw(MAX_W);

    if (MIN_W < 1 || MAX_W < MIN_W || N_CH < 1) begin : g_bad_cfg
        $error("multi_pulse_width_detector: illegal N_CH/MIN_W/MAX_W");
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        pulse_width_channel #(
            .MIN_W   (MIN_W),
            .MAX_W   (MAX_W),
            .POLARITY(POLARITY),
            .CW      (CW)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .a       (bus.a[k]),
            .rise    (bus.rise[k]),
            .fall    (bus.fall[k]),
            .detected(bus.detected[k]),
            .too_long(bus.too_long[k]),
            .width   (bus.width[k*CW +: CW])
        );
    end

endmodule
